// File: rtl/data_mem_arbiter_if.sv
// Bus bundle for data_mem_arbiter: pipeline M-stage port, loader port and DataMemory port.
// The arbiter uses the slave modport; requesters and the memory model use master.
interface data_mem_arbiter_if #(
    parameter int D_WIDTH  = 32,
    parameter int AD_WIDTH = 32
);
    logic                MemReqM;
    logic                MemWriteM;
    logic                a_typeM;
    logic [AD_WIDTH-1:0] ALUResultM;
    logic [D_WIDTH-1:0]  WriteDataM;
    logic [D_WIDTH-1:0]  ReadDataM;
    logic                StallM;

    logic                ldr_req;
    logic                ldr_we;
    logic [AD_WIDTH-1:0] ldr_addr;
    logic [D_WIDTH-1:0]  ldr_wdata;
    logic                ldr_gnt;
    logic                ldr_rvalid;
    logic [D_WIDTH-1:0]  ldr_rdata;

    logic                mem_we;
    logic                mem_adtp;
    logic [AD_WIDTH-1:0] mem_addr;
    logic [D_WIDTH-1:0]  mem_wd;
    logic [D_WIDTH-1:0]  mem_rd;

    modport master (
        output MemReqM, MemWriteM, a_typeM, ALUResultM, WriteDataM,
        input  ReadDataM, StallM,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  ldr_gnt, ldr_rvalid, ldr_rdata,
        input  mem_we, mem_adtp, mem_addr, mem_wd,
        output mem_rd
    );

    modport slave (
        input  MemReqM, MemWriteM, a_typeM, ALUResultM, WriteDataM,
        output ReadDataM, StallM,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output ldr_gnt, ldr_rvalid, ldr_rdata,
        output mem_we, mem_adtp, mem_addr, mem_wd,
        input  mem_rd
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Pipeline/loader arbiter in front of the single-port DataMemory with a fixed-latency access FSM.
// Define ARB_STARVE_GUARD_EN to enable the loader starvation guard (forced loader grant).
module data_mem_arbiter #(
    parameter int D_WIDTH    = 32,
    parameter int AD_WIDTH   = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input logic               clk,
    input logic               rst,
    data_mem_arbiter_if.slave bus
);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
    typedef enum logic {PIPE = 1'b0, LDR = 1'b1} owner_t;

    if (MEM_LAT < 1 || STARVE_MAX < 1) begin : g_bad_params
        $error("data_mem_arbiter: MEM_LAT and STARVE_MAX must be >= 1");
    end

    state_t              state_r;
    state_t              next_state_s;
    owner_t              owner_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                we_r;
    logic                adtp_r;
    logic [AD_WIDTH-1:0] addr_r;
    logic [D_WIDTH-1:0]  wdata_r;
    logic [D_WIDTH-1:0]  rdata_r;
    logic                grant_s;
    logic                ldr_win_s;
    logic                guard_fire_s;

`ifdef ARB_STARVE_GUARD_EN
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_MAX);

    logic [STV_W-1:0] starve_r;

    // Saturating count of arbitrations the waiting loader has lost; cleared by any loader grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_r <= {STV_W{1'b0}};
        end else if (grant_s && ldr_win_s) begin
            starve_r <= {STV_W{1'b0}};
        end else if (grant_s && bus.ldr_req && (starve_r != STV_MAX)) begin
            starve_r <= starve_r + STV_W'(1);
        end else begin
            starve_r <= starve_r;
        end
    end

    assign guard_fire_s = (starve_r == STV_MAX);
`else
    assign guard_fire_s = 1'b0;
`endif

    // Next state and arbitration; a grant is only ever issued from IDLE.
    always_comb begin
        next_state_s = state_r;
        grant_s      = 1'b0;
        ldr_win_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.MemReqM || bus.ldr_req) begin
                    grant_s      = 1'b1;
                    ldr_win_s    = bus.ldr_req && (!bus.MemReqM || guard_fire_s);
                    next_state_s = BUSY;
                end else begin
                    next_state_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == CNT_LAST) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = BUSY;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register, request latch from the winner, occupancy counter and read capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            owner_r <= PIPE;
            cnt_r   <= {CNT_W{1'b0}};
            we_r    <= 1'b0;
            adtp_r  <= 1'b0;
            addr_r  <= {AD_WIDTH{1'b0}};
            wdata_r <= {D_WIDTH{1'b0}};
            rdata_r <= {D_WIDTH{1'b0}};
        end else begin
            state_r <= next_state_s;
            if (grant_s) begin
                cnt_r <= {CNT_W{1'b0}};
                if (ldr_win_s) begin
                    owner_r <= LDR;
                    we_r    <= bus.ldr_we;
                    adtp_r  <= 1'b0;
                    addr_r  <= bus.ldr_addr;
                    wdata_r <= bus.ldr_wdata;
                end else begin
                    owner_r <= PIPE;
                    we_r    <= bus.MemWriteM;
                    adtp_r  <= bus.a_typeM;
                    addr_r  <= bus.ALUResultM;
                    wdata_r <= bus.WriteDataM;
                end
            end else if (state_r == BUSY) begin
                cnt_r <= cnt_r + CNT_W'(1);
                if (cnt_r == CNT_LAST) begin
                    rdata_r <= bus.mem_rd;
                end else begin
                    rdata_r <= rdata_r;
                end
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Memory drive only while BUSY (write strobe on the first cycle), completion only in DONE.
    always_comb begin
        bus.mem_we     = 1'b0;
        bus.mem_adtp   = 1'b0;
        bus.mem_addr   = {AD_WIDTH{1'b0}};
        bus.mem_wd     = {D_WIDTH{1'b0}};
        bus.ReadDataM  = {D_WIDTH{1'b0}};
        bus.ldr_rvalid = 1'b0;
        bus.ldr_rdata  = {D_WIDTH{1'b0}};
        bus.ldr_gnt    = grant_s && ldr_win_s && !rst;
        bus.StallM     = bus.MemReqM && !((state_r == DONE) && (owner_r == PIPE));
        if (state_r == BUSY) begin
            bus.mem_we   = we_r && (cnt_r == {CNT_W{1'b0}});
            bus.mem_adtp = adtp_r;
            bus.mem_addr = addr_r;
            bus.mem_wd   = wdata_r;
        end else if (state_r == DONE) begin
            if (owner_r == PIPE) begin
                bus.ReadDataM = rdata_r;
            end else begin
                bus.ldr_rvalid = 1'b1;
                bus.ldr_rdata  = rdata_r;
            end
        end else begin
            bus.mem_we = 1'b0;
        end
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed plus randomized bench for data_mem_arbiter against a transaction-level reference
// (reference memory, per-access latency and a loader-loss counter); honours ARB_STARVE_GUARD_EN.
module tb_data_mem_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int ML = 3;
    localparam int SM = 2;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_arbiter_if #(.D_WIDTH(DW), .AD_WIDTH(AW)) bus ();

    data_mem_arbiter #(.D_WIDTH(DW), .AD_WIDTH(AW), .MEM_LAT(ML), .STARVE_MAX(SM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] dmem    [0:255];
    logic [31:0] ref_mem [0:255];
    int          we_cnt  = 0;
    int          vectors = 0;
    int          errors  = 0;

    logic       p_we;
    logic       p_adtp;
    logic [7:0] p_addr;
    logic [31:0] p_wdata;

    assign bus.mem_rd = dmem[bus.mem_addr[7:0]];

    always @(posedge clk) if (bus.mem_we) dmem[bus.mem_addr[7:0]] <= bus.mem_wd;
    always @(negedge clk) if (bus.mem_we) we_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic drive_pipe(input logic we, input logic [7:0] a, input logic [31:0] d);
        p_we = we; p_addr = a; p_wdata = d; p_adtp = 1'($urandom_range(0, 1));
        bus.MemReqM = 1'b1; bus.MemWriteM = we; bus.a_typeM = p_adtp;
        bus.ALUResultM = {24'h0, a}; bus.WriteDataM = d;
    endtask

    // Entered in the grant cycle (+1); returns at the first IDLE negedge after completion.
    task automatic pipe_finish();
        int n;
        int w0;
        w0 = we_cnt;
        n  = 1;
        while (bus.StallM === 1'b1 && n < 200) begin
            @(negedge clk); #1;
            n++;
            if (n == 2) begin
                chk("pipe_mem_addr", bus.mem_addr, {24'h0, p_addr});
                chk1("pipe_mem_adtp", bus.mem_adtp, p_adtp);
            end
        end
        chk("pipe_latency", n, ML + 2);
        chk1("pipe_no_rvalid", bus.ldr_rvalid, 1'b0);
        if (p_we) ref_mem[p_addr] = p_wdata;
        else      chk("pipe_rdata", bus.ReadDataM, ref_mem[p_addr]);
        chk("pipe_we_pulses", we_cnt - w0, p_we ? 1 : 0);
        @(negedge clk);
    endtask

    task automatic pipe_access(input logic we, input logic [7:0] a, input logic [31:0] d);
        bus.ldr_req = 1'b0;
        drive_pipe(we, a, d);
        #1;
        chk1("pipe_no_gnt", bus.ldr_gnt, 1'b0);
        pipe_finish();
        bus.MemReqM = 1'b0;
    endtask

    task automatic ldr_access(input logic we, input logic [7:0] a, input logic [31:0] d);
        int n;
        int w0;
        bus.MemReqM = 1'b0; bus.ldr_req = 1'b1; bus.ldr_we = we;
        bus.ldr_addr = {24'h0, a}; bus.ldr_wdata = d;
        #1;
        chk1("ldr_gnt", bus.ldr_gnt, 1'b1);
        w0 = we_cnt;
        @(negedge clk);
        bus.ldr_req = 1'b0; bus.ldr_we = ~we; bus.ldr_addr = $urandom; bus.ldr_wdata = $urandom;
        #1;
        chk1("ldr_gnt_one_cycle", bus.ldr_gnt, 1'b0);
        chk("ldr_mem_addr", bus.mem_addr, {24'h0, a});
        chk1("ldr_mem_adtp", bus.mem_adtp, 1'b0);
        n = 1;
        while (bus.ldr_rvalid !== 1'b1 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        chk("ldr_latency", n, ML + 1);
        if (we) ref_mem[a] = d;
        else    chk("ldr_rdata", bus.ldr_rdata, ref_mem[a]);
        chk("ldr_we_pulses", we_cnt - w0, we ? 1 : 0);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] la;
        bit         pend;
        bit         exp_l;
        int         waits;

        for (int i = 0; i < 256; i++) begin
            dmem[i]    = 32'h0101_0101 * i;
            ref_mem[i] = 32'h0101_0101 * i;
        end
        dmem[8'h10] = 32'hDEAD_BEEF; ref_mem[8'h10] = 32'hDEAD_BEEF;
        bus.MemReqM = 1'b1; bus.MemWriteM = 1'b0; bus.a_typeM = 1'b0;
        bus.ALUResultM = 32'h0; bus.WriteDataM = 32'h0;
        bus.ldr_req = 1'b1; bus.ldr_we = 1'b0; bus.ldr_addr = 32'h0; bus.ldr_wdata = 32'h0;

        // Reset state
        @(negedge clk); #1;
        chk1("rst_stall_follows_req", bus.StallM, 1'b1);
        chk1("rst_gnt", bus.ldr_gnt, 1'b0);
        chk1("rst_rvalid", bus.ldr_rvalid, 1'b0);
        chk1("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_readdata", bus.ReadDataM, 32'h0);
        bus.MemReqM = 1'b0; bus.ldr_req = 1'b0; #1;
        chk1("rst_stall_low", bus.StallM, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Directed accesses
        pipe_access(1'b0, 8'h10, 32'h0);
        pipe_access(1'b1, 8'h20, 32'h1234_5678);
        pipe_access(1'b0, 8'h20, 32'h0);
        ldr_access(1'b1, 8'h40, 32'hCAFE_F00D);
        ldr_access(1'b0, 8'h40, 32'h0);

        // Randomized mix
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 1)
                pipe_access(1'($urandom_range(0, 1)), 8'($urandom_range(0, 63)), $urandom);
            else
                ldr_access(1'($urandom_range(0, 1)), 8'($urandom_range(0, 63)), $urandom);
        end

        // Contention: loader held, pipeline presents back-to-back requests
        la = 8'h33; pend = 1'b1; waits = 0;
        bus.ldr_req = 1'b1; bus.ldr_we = 1'b0; bus.ldr_addr = {24'h0, la};
        for (int k = 0; k < SM + 2; k++) begin
            drive_pipe(1'($urandom_range(0, 1)), 8'($urandom_range(0, 63)), $urandom);
            #1;
            exp_l = pend && GUARD && (waits == SM);
            chk1("ctn_gnt", bus.ldr_gnt, exp_l);
            if (bus.ldr_gnt === 1'b1) begin
                pend = 1'b0; waits = 0;
                @(negedge clk);
                bus.ldr_req = 1'b0;
                for (int i = 0; i < ML; i++) @(negedge clk);
                #1;
                chk1("ctn_ldr_rvalid", bus.ldr_rvalid, 1'b1);
                chk("ctn_ldr_rdata", bus.ldr_rdata, ref_mem[la]);
                chk1("ctn_pipe_still_stalled", bus.StallM, 1'b1);
                @(negedge clk); #1;
                chk1("ctn_pipe_after_ldr", bus.ldr_gnt, 1'b0);
            end else if (pend && waits < SM) begin
                waits++;
            end
            pipe_finish();
        end
        bus.MemReqM = 1'b0;
        if (pend) begin
            #1;
            chk1("ctn_gnt_idle", bus.ldr_gnt, 1'b1);
            @(negedge clk);
            bus.ldr_req = 1'b0;
            for (int i = 0; i < ML; i++) @(negedge clk);
            #1;
            chk1("ctn_idle_rvalid", bus.ldr_rvalid, 1'b1);
            chk("ctn_idle_rdata", bus.ldr_rdata, ref_mem[la]);
            @(negedge clk);
        end

        // Reset in the middle of a loader read
        bus.ldr_req = 1'b1; bus.ldr_we = 1'b0; bus.ldr_addr = 32'h5; #1;
        chk1("mid_gnt", bus.ldr_gnt, 1'b1);
        @(negedge clk);
        bus.ldr_req = 1'b0; bus.MemReqM = 1'b1; rst = 1'b1; #1;
        chk1("mid_rvalid", bus.ldr_rvalid, 1'b0);
        chk1("mid_mem_we", bus.mem_we, 1'b0);
        chk("mid_mem_addr", bus.mem_addr, 32'h0);
        chk("mid_ldr_rdata", bus.ldr_rdata, 32'h0);
        chk1("mid_stall_follows_req", bus.StallM, 1'b1);
        for (int i = 0; i < ML + 2; i++) begin
            @(negedge clk); #1;
            chk1("mid_no_rvalid", bus.ldr_rvalid, 1'b0);
        end
        @(negedge clk);
        bus.MemReqM = 1'b0; rst = 1'b0;
        pipe_access(1'b0, 8'h40, 32'h0);
        pipe_access(1'b0, 8'h20, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
